// File: rtl/log_mel_if.sv
// Sample-in / band-out handshake for the log-mel front end.
interface log_mel_if #(
    parameter int I_BW = 14,
    parameter int O_BW = 14
);
    logic                   di_en;
    logic signed [I_BW-1:0] data_i;
    logic                   do_en;
    logic [O_BW-1:0]        data_o;

    modport master (output di_en, data_i, input do_en, data_o);
    modport slave  (input di_en, data_i, output do_en, data_o);
endinterface

// File: rtl/log_mel_spectrogram_core.sv
// Log-mel front end: 16-sample frame -> 9-bin real DFT power -> 4 triangular
// mel bands -> log2 U6.8 words, emitted as a 4-cycle burst.
// Build option: define LOGMEL_LINEAR_OUT_EN to bypass the log stage and emit
// band energy saturated to O_BW bits; timing is identical either way.
module log_mel_spectrogram_core #(
    parameter int I_BW  = 14,
    parameter int O_BW  = 14,
    parameter int FRAME = 16,
    parameter int N_MEL = 4
) (
    input  logic     clk,
    input  logic     rst,
    log_mel_if.slave io
);
    localparam int N_BIN = 9;
    localparam int CW    = $clog2(FRAME);
    localparam int MW    = $clog2(N_MEL);
    localparam int AW    = 26;
    localparam int EW    = 37;
    localparam int SW    = 45;

    typedef enum logic [1:0] {COLLECT, DFT, MEL, OUT} state_t;
    state_t state_q, state_d;

    logic signed [I_BW-1:0] smp [FRAME];
    logic [CW-1:0]          cnt_q;
    logic [3:0]             bin_q;
    logic signed [AW-1:0]   acc_re_q, acc_im_q;
    logic [32:0]            pwr_q [N_BIN];
    logic [EW-1:0]          eng_q [N_MEL];
    logic [EW-1:0]          eng_d [N_MEL];
    logic [MW-1:0]          oidx_q;
    logic                   do_en_q;
    logic [O_BW-1:0]        data_o_q;

    logic last_smp, last_bin, last_out;
    assign last_smp = (cnt_q == CW'(FRAME - 1));
    assign last_bin = (bin_q == 4'(N_BIN - 1));
    assign last_out = (oidx_q == MW'(N_MEL - 1));

    // round(127*cos(2*pi*j/16)); sine is read as cos(j-4)
    function automatic logic signed [7:0] cos_t(input logic [3:0] j);
        logic signed [7:0] c;
        case (j)
            4'd0:    c =  8'sd127;
            4'd1:    c =  8'sd117;
            4'd2:    c =  8'sd90;
            4'd3:    c =  8'sd49;
            4'd4:    c =  8'sd0;
            4'd5:    c = -8'sd49;
            4'd6:    c = -8'sd90;
            4'd7:    c = -8'sd117;
            4'd8:    c = -8'sd127;
            4'd9:    c = -8'sd117;
            4'd10:   c = -8'sd90;
            4'd11:   c = -8'sd49;
            4'd12:   c =  8'sd0;
            4'd13:   c =  8'sd49;
            4'd14:   c =  8'sd90;
            default: c =  8'sd117;
        endcase
        return c;
    endfunction

    // Triangular mel weights; edges (0,1,2) (1,2,4) (2,4,6) (4,6,8)
    function automatic logic [7:0] mel_w(input int m, input int k);
        logic [7:0] w;
        case (m)
            0:       w = (k == 1) ? 8'd255 : 8'd0;
            1:       w = (k == 2) ? 8'd255 : (k == 3) ? 8'd128 : 8'd0;
            2:       w = (k == 4) ? 8'd255 : (k == 3 || k == 5) ? 8'd128 : 8'd0;
            default: w = (k == 6) ? 8'd255 : (k == 5 || k == 7) ? 8'd128 : 8'd0;
        endcase
        return w;
    endfunction

    // Output word formatting: log2 U6.8 or saturated linear energy
    function automatic logic [O_BW-1:0] fmt_out(input logic [EW-1:0] e);
`ifdef LOGMEL_LINEAR_OUT_EN
        return (e > EW'(2**O_BW - 1)) ? '1 : e[O_BW-1:0];
`else
        logic [5:0]       p;
        logic [EW+7:0]    sh;
        p = '0;
        for (int i = 0; i < EW; i++)
            if (e[i]) p = 6'(i);
        // leading one lands on bit 8, the 8 bits below it fill [7:0]
        sh = {e, 8'b0} >> p;
        return (e == '0) ? '0 : O_BW'({p, sh[7:0]});
`endif
    endfunction

    // DFT MAC datapath: one sample x one twiddle per cycle
    logic [3:0]           tw_j;
    logic signed [AW-1:0] x_ext, c_ext, s_ext, sum_re, sum_im;
    logic signed [15:0]   re_s, im_s;
    logic signed [31:0]   sq_re, sq_im;
    logic [32:0]          pwr_new;

    assign tw_j    = 4'(bin_q * cnt_q);
    assign x_ext   = AW'(smp[cnt_q]);
    assign c_ext   = AW'(cos_t(tw_j));
    assign s_ext   = AW'(cos_t(tw_j - 4'd4));
    assign sum_re  = acc_re_q + x_ext * c_ext;
    assign sum_im  = acc_im_q - x_ext * s_ext;
    assign re_s    = sum_re[AW-1:10];
    assign im_s    = sum_im[AW-1:10];
    assign sq_re   = 32'(re_s) * 32'(re_s);
    assign sq_im   = 32'(im_s) * 32'(im_s);
    assign pwr_new = {1'b0, sq_re} + {1'b0, sq_im};

    // Mel band energies from the stored bin powers (weights are constants)
    logic [SW-1:0] msum;
    always_comb begin
        msum = '0;
        for (int m = 0; m < N_MEL; m++) begin
            msum = '0;
            for (int k = 0; k < N_BIN; k++)
                msum = msum + SW'(pwr_q[k]) * SW'(mel_w(m, k));
            eng_d[m] = EW'(msum >> 8);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= COLLECT;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: if (io.di_en && last_smp) state_d = DFT;
            DFT:     if (last_smp && last_bin) state_d = MEL;
            MEL:     state_d = OUT;
            OUT:     if (last_out) state_d = COLLECT;
            default: state_d = COLLECT;
        endcase
    end

    // Datapath: sample capture, MAC, power/energy registers, output burst
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q    <= '0;
            bin_q    <= '0;
            acc_re_q <= '0;
            acc_im_q <= '0;
            oidx_q   <= '0;
            do_en_q  <= 1'b0;
            data_o_q <= '0;
        end else begin
            do_en_q <= 1'b0;
            case (state_q)
                COLLECT: begin
                    bin_q    <= '0;
                    acc_re_q <= '0;
                    acc_im_q <= '0;
                    if (io.di_en) begin
                        smp[cnt_q] <= io.data_i;
                        cnt_q      <= cnt_q + 1'b1;
                    end
                end
                DFT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (last_smp) begin
                        pwr_q[bin_q] <= pwr_new;
                        acc_re_q     <= '0;
                        acc_im_q     <= '0;
                        bin_q        <= bin_q + 1'b1;
                    end else begin
                        acc_re_q <= sum_re;
                        acc_im_q <= sum_im;
                    end
                end
                MEL: begin
                    eng_q  <= eng_d;
                    oidx_q <= '0;
                end
                OUT: begin
                    do_en_q  <= 1'b1;
                    data_o_q <= fmt_out(eng_q[oidx_q]);
                    oidx_q   <= oidx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign io.do_en  = do_en_q;
    assign io.data_o = data_o_q;
endmodule

// File: tb/tb_log_mel_spectrogram_core.sv
// Scoreboard bench for log_mel_spectrogram_core: a frame-level reference
// model (real-valued twiddles, formula mel weights) fills an expected queue as
// samples are accepted; a negedge monitor pops and compares each output word.
module tb_log_mel_spectrogram_core;
    localparam int I_BW = 14, O_BW = 14, FRAME = 16, N_MEL = 4;
    localparam int LAT_MAX = 200;
    localparam real PI = 3.14159265358979;

    logic clk = 1'b0;
    logic rst;
    log_mel_if #(.I_BW(I_BW), .O_BW(O_BW)) ifc();

    log_mel_spectrogram_core #(.I_BW(I_BW), .O_BW(O_BW), .FRAME(FRAME), .N_MEL(N_MEL)) dut (
        .clk (clk),
        .rst (rst),
        .io  (ifc)
    );

    always #5 clk = ~clk;

    int     ct[16], st[16], wt[4][9];
    int     exp_q[$];
    longint acc_q[$];
    int     fbuf[$];
    bit     busy = 1'b0;
    longint cyc = 0;
    int     run = 0;
    int     ref_lat = -1;
    int     checks = 0, passes = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        checks++;
        if (ok) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int fmt_ref(input longint e);
`ifdef LOGMEL_LINEAR_OUT_EN
        return (e > 2**O_BW - 1) ? 2**O_BW - 1 : int'(e);
`else
        int p;
        longint fr;
        if (e == 0) return 0;
        p = 0;
        while ((e >> (p + 1)) != 0) p++;
        fr = ((e - (longint'(1) << p)) << 8) >> p;
        return p * 256 + int'(fr);
`endif
    endfunction

    // Whole-frame reference: DFT power, mel energy, output word per band
    function automatic void model_push(input int x[$]);
        longint p[9];
        longint e;
        int re, im;
        for (int k = 0; k < 9; k++) begin
            re = 0; im = 0;
            for (int n = 0; n < FRAME; n++) begin
                re += x[n] * ct[(k * n) % 16];
                im -= x[n] * st[(k * n) % 16];
            end
            re = re >>> 10;
            im = im >>> 10;
            p[k] = longint'(re) * re + longint'(im) * im;
        end
        for (int m = 0; m < N_MEL; m++) begin
            e = 0;
            for (int k = 0; k < 9; k++) e += p[k] * wt[m][k];
            exp_q.push_back(fmt_ref(e >> 8));
        end
    endfunction

    // Monitor: compare outputs, then decide what the next edge accepts
    always @(negedge clk) begin
        longint lat;
        int w;
        if (ifc.do_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_do_en", ifc.do_en == 1'b0, ifc.do_en, 0);
            end else begin
                if (run == 0 && acc_q.size() > 0) begin
                    lat = cyc - acc_q.pop_front();
                    check("latency", lat <= LAT_MAX && (ref_lat < 0 || lat == ref_lat),
                          lat, (ref_lat < 0) ? LAT_MAX : ref_lat);
                    if (ref_lat < 0) ref_lat = int'(lat);
                end
                w = exp_q.pop_front();
                check($sformatf("band%0d", run), ifc.data_o == O_BW'(w), ifc.data_o, w);
            end
            run++;
            if (run == N_MEL) busy = 1'b0;
        end else if (run > 0) begin
            check("burst_len", run == N_MEL, run, N_MEL);
            run = 0;
        end

        if (rst == 1'b0) begin
            fbuf.delete();
            if (busy) begin
                repeat (N_MEL) void'(exp_q.pop_back());
                void'(acc_q.pop_back());
                busy = 1'b0;
            end
        end else if (!busy && ifc.di_en) begin
            fbuf.push_back(int'(ifc.data_i));
            if (fbuf.size() == FRAME) begin
                model_push(fbuf);
                acc_q.push_back(cyc + 1);
                busy = 1'b1;
                fbuf.delete();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gap: 0 none, 1 idle cycle before each sample, 2 random idles
    task automatic drive_frame(input int x[FRAME], input int gap);
        for (int n = 0; n < FRAME; n++) begin
            if (gap == 1 || (gap == 2 && $urandom_range(1) == 0)) begin
                ifc.di_en  = 1'b0;
                ifc.data_i = I_BW'($urandom);
                tick();
            end
            ifc.di_en  = 1'b1;
            ifc.data_i = I_BW'(x[n]);
            tick();
        end
        ifc.di_en = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || exp_q.size() != 0) && t < 400) begin
            tick();
            t++;
        end
        check("drain", !busy && exp_q.size() == 0, exp_q.size(), 0);
        repeat (3) tick();
    endtask

    initial begin
        int x[FRAME];
        int tone[FRAME];
        int be[4][3];
        be = '{'{0, 1, 2}, '{1, 2, 4}, '{2, 4, 6}, '{4, 6, 8}};
        for (int j = 0; j < 16; j++) begin
            ct[j] = int'($floor(127.0 * $cos(2.0 * PI * j / 16.0) + 0.5));
            st[j] = int'($floor(127.0 * $sin(2.0 * PI * j / 16.0) + 0.5));
        end
        for (int m = 0; m < 4; m++)
            for (int k = 0; k < 9; k++) begin
                if (k <= be[m][0] || k >= be[m][2]) wt[m][k] = 0;
                else if (k == be[m][1]) wt[m][k] = 255;
                else if (k < be[m][1]) wt[m][k] = 256 * (k - be[m][0]) / (be[m][1] - be[m][0]);
                else wt[m][k] = 256 * (be[m][2] - k) / (be[m][2] - be[m][1]);
                if (wt[m][k] > 255) wt[m][k] = 255;
            end
        for (int n = 0; n < FRAME; n++)
            tone[n] = int'($floor(1000.0 * $cos(2.0 * PI * 2.0 * n / 16.0) + 0.5));

        rst = 1'b0;
        ifc.di_en = 1'b0;
        ifc.data_i = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_do_en", ifc.do_en == 1'b0, ifc.do_en, 0);
        check("rst_data_o", ifc.data_o == '0, ifc.data_o, 0);
        tick();
        rst = 1'b1;
        tick();

        foreach (x[n]) x[n] = 0;
        drive_frame(x, 0);
        wait_idle();

        foreach (x[n]) x[n] = 1000;
        drive_frame(x, 0);
        wait_idle();

        drive_frame(tone, 0);
        wait_idle();

        drive_frame(tone, 1);
        wait_idle();

        // partial frame cut by a one-cycle reset, then a clean frame
        for (int n = 0; n < 10; n++) begin
            ifc.di_en  = 1'b1;
            ifc.data_i = I_BW'(tone[n]);
            tick();
        end
        ifc.di_en = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        drive_frame(tone, 0);
        wait_idle();

        // back-to-back: samples keep streaming while the core is busy
        foreach (x[n]) x[n] = int'($urandom_range(16383)) - 8192;
        drive_frame(x, 0);
        repeat (200) begin
            ifc.di_en  = 1'b1;
            ifc.data_i = I_BW'($urandom);
            tick();
        end
        ifc.di_en = 1'b0;
        wait_idle();

        // full-scale extremes
        foreach (x[n]) x[n] = (n % 2 == 0) ? 8191 : -8192;
        drive_frame(x, 0);
        wait_idle();
        foreach (x[n]) x[n] = -8192;
        drive_frame(x, 2);
        wait_idle();

        // random frames with random gaps
        repeat (6) begin
            foreach (x[n]) x[n] = int'($urandom_range(16383)) - 8192;
            drive_frame(x, 2);
            wait_idle();
        end

        check("final_queue", exp_q.size() == 0, exp_q.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
